regfile_wr_arbiter: RTL and testbench
=====================================

// Module: regfile_wr_arbiter
// PURPOSE
//  Owns the 32x32 integer register file and sequences all accesses to it.
//  - After reset or soft clear: an init FSM zeroes every entry.
//  - Afterwards: two writeback requesters (req0 = ALU, req1 = load unit) share the
//    single write port under round-robin arbitration with valid/ready handshakes.
//  - Two combinational read ports (rs1/rs2) serve the decode stage.
// PARAMETERS
//  XLEN  32             data width of each register
//  NREG  32             number of registers (power of two)
//  AW    $clog2(NREG)   register address width (derived; do not override)
// PORTS
//  clk         in   1     single clock, rising edge
//  rst_n       in   1     reset, asynchronous assert, active-low
//  clr         in   1     synchronous soft clear request (re-runs init)
//  req0_valid  in   1     requester 0 has a write pending
//  req0_addr   in   AW    requester 0 destination register
//  req0_data   in   XLEN  requester 0 write data
//  req0_ready  out  1     requester 0 write accepted this cycle
//  req1_valid  in   1     requester 1 has a write pending
//  req1_addr   in   AW    requester 1 destination register
//  req1_data   in   XLEN  requester 1 write data
//  req1_ready  out  1     requester 1 write accepted this cycle
//  rs1         in   AW    read port 1 address
//  rs2         in   AW    read port 2 address
//  rs1_data    out  XLEN  read port 1 data (combinational)
//  rs2_data    out  XLEN  read port 2 data (combinational)
//  init_busy   out  1     high while the init sequence runs
// BEHAVIOUR
//  - FSM states: INIT, RUN.
//  - Reset (rst_n low, async):
//    - state=INIT, init_idx=0, last_grant=1 (req0 wins the first tie).
//    - Outputs: init_busy=1, req0_ready=req1_ready=0.
//    - Storage is not reset directly; INIT clears it.
//  - INIT: each cycle write 0 to mem[init_idx], then init_idx++.
//    - After the write at idx NREG-1, go to RUN: exactly NREG cycles after rst_n rises.
//    - Counter is AW+1 bits so the terminal count needs no wrap compare.
//    - Holds: both ready=0, init_busy=1, rs1_data=rs2_data=0.
//    - clr is ignored during INIT.
//  - RUN: init_busy=0.
//    - Winner = the only valid requester. If both are valid, winner = the one
//      not equal to last_grant.
//    - ready[winner]=1 in the same cycle (combinational from valid); loser ready=0.
//    - ready never asserts without the matching valid.
//    - An accepted write updates mem[addr] at the rising edge.
//    - last_grant <= winner on every accepted transfer; it holds when idle.
//    - Throughput: one write per cycle. A requester held valid against a
//      continuously valid peer is granted within 2 cycles.
//  - Register x0: writes to addr 0 are accepted (ready=1) and discarded.
//    Reads of addr 0 always return 0.
//  - Read timing: no write-to-read bypass. A read of the address being written
//    returns the old value that cycle and the new value the next cycle.
//  - clr=1 in RUN:
//    - An arbitrated write in that same cycle still completes.
//    - Next state is INIT with init_idx=0, so that write is cleared later.
//  - rst_n asserted mid-INIT or mid-RUN: immediate return to INIT, init_idx=0.
//    In-flight handshakes are dropped.
// STRUCTURE
//  - Package regfile_pkg: XLEN_DEF, NREG_DEF constants; typedef reg_addr_t,
//    xlen_t; enum rf_state_e {INIT, RUN}.
//  - Sub-module regfile_2r1w: storage array with 2 async read ports, 1 sync
//    write port and x0 read-as-zero. This block holds the FSM, init counter,
//    arbiter and write mux.
// TESTING
//  1. Release rst_n, no requests. Check:
//     - init_busy high for exactly 32 cycles; ready=0 throughout.
//     - Then read every rs1/rs2 address -> all 0.
//  2. After init: req0 writes x5=0xDEADBEEF, alone.
//     - req0_ready=1 that cycle.
//     - Next cycle rs1=5 -> 0xDEADBEEF.
//  3. Both valid continuously for 4 cycles: req0 to x1, req1 to x2.
//     - Grants alternate 0,1,0,1.
//     - Final values x1=req0 data, x2=req1 data.
//  4. req1 writes x0=0x12345678 -> req1_ready=1; rs2=0 still reads 0.
//  5. Write x7=0xA5A5A5A5, then pulse clr together with a write of x8=0x1.
//     - The write to x8 is accepted.
//     - init_busy high for 32 cycles.
//     - Afterwards x7=x8=0.
//  6. Assert rst_n low at init_idx=10 for 1 cycle.
//     - init restarts from idx 0.
//     - init_busy is held for 32 further cycles after release.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the integer register file block.
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int AW_DEF   = $clog2(NREG_DEF);

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xlen_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_e;

    // Round-robin pick between two requesters. Returns a one-hot grant
    // ({gnt1, gnt0}). On a tie the requester that did not win last time wins.
    function automatic logic [1:0] rr_pick(input logic v0, input logic v1,
                                           input logic last);
        logic [1:0] g;
        g = 2'b00;
        if (v0 && v1)
            g = last ? 2'b01 : 2'b10;
        else if (v0)
            g = 2'b01;
        else if (v1)
            g = 2'b10;
        return g;
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Register storage: two asynchronous read ports, one synchronous write port.
// Entry 0 is hardwired to zero on reads and never written.
module regfile_2r1w #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] mem [NREG];

    // Storage has no reset; the owner clears it by writing zeros.
    always_ff @(posedge clk) begin
        if (we && (waddr != '0))
            mem[waddr] <= wdata;
    end

    // Reads see the pre-write contents in the cycle a write lands.
    assign rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register file owner: clears storage after reset/clear, then arbitrates
// two writeback requesters round-robin onto the single write port.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter  int XLEN = XLEN_DEF,
    parameter  int NREG = NREG_DEF,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            req0_valid,
    input  logic [AW-1:0]   req0_addr,
    input  logic [XLEN-1:0] req0_data,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [AW-1:0]   req1_addr,
    input  logic [XLEN-1:0] req1_data,
    output logic            req1_ready,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            init_busy
);

    rf_state_e       state, state_nxt;
    // One extra bit: the MSB sets exactly when the last entry has been cleared.
    logic [AW:0]     init_idx, init_idx_nxt;
    logic            last_grant, last_grant_nxt;
    logic [1:0]      gnt;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] rd1, rd2;

    // Control state; last_grant=1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT;
            init_idx   <= '0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            init_idx   <= init_idx_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Next state, arbitration and write-port mux.
    always_comb begin
        state_nxt      = state;
        init_idx_nxt   = init_idx;
        last_grant_nxt = last_grant;
        gnt            = 2'b00;
        we             = 1'b0;
        waddr          = '0;
        wdata          = '0;
        init_busy      = 1'b0;
        case (state)
            INIT: begin
                // Sweep every entry with zero; clr has no effect here.
                init_busy    = 1'b1;
                we           = 1'b1;
                waddr        = init_idx[AW-1:0];
                init_idx_nxt = init_idx + (AW+1)'(1);
                if (init_idx_nxt[AW]) begin
                    state_nxt    = RUN;
                    init_idx_nxt = '0;
                end
            end
            RUN: begin
                gnt = rr_pick(req0_valid, req1_valid, last_grant);
                if (gnt[0]) begin
                    we             = 1'b1;
                    waddr          = req0_addr;
                    wdata          = req0_data;
                    last_grant_nxt = 1'b0;
                end else if (gnt[1]) begin
                    we             = 1'b1;
                    waddr          = req1_addr;
                    wdata          = req1_data;
                    last_grant_nxt = 1'b1;
                end
                // A write granted alongside clr still lands; the sweep
                // that follows wipes it again.
                if (clr) begin
                    state_nxt    = INIT;
                    init_idx_nxt = '0;
                end
            end
            default: begin
                state_nxt    = INIT;
                init_idx_nxt = '0;
            end
        endcase
    end

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    regfile_2r1w #(
        .XLEN (XLEN),
        .NREG (NREG),
        .AW   (AW)
    ) u_rf (
        .clk    (clk),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rd1),
        .rdata2 (rd2)
    );

    // Storage is only partly cleared during the sweep, so reads are masked.
    assign rs1_data = (state == INIT) ? '0 : rd1;
    assign rs2_data = (state == INIT) ? '0 : rd2;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: vector table, directed
// corner sequences and a randomized run against a behavioural model.
module tb_regfile_wr_arbiter;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            clr = 1'b0;
    logic            req0_valid = 1'b0;
    logic [AW-1:0]   req0_addr = '0;
    logic [XLEN-1:0] req0_data = '0;
    logic            req0_ready;
    logic            req1_valid = 1'b0;
    logic [AW-1:0]   req1_addr = '0;
    logic [XLEN-1:0] req1_data = '0;
    logic            req1_ready;
    logic [AW-1:0]   rs1 = '0;
    logic [AW-1:0]   rs2 = '0;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            init_busy;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_wr_arbiter #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rs1        (rs1),
        .rs2        (rs2),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .init_busy  (init_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        e_rdy0;
        logic        e_rdy1;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                         input logic [4:0] r1, input logic [4:0] r2, input logic c);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        rs1 = r1; rs2 = r2; clr = c;
    endtask

    // Counts consecutive busy cycles from now (called #1 after a negedge);
    // readies and read data must stay 0 throughout. clr_at pulses clr.
    task automatic count_busy(input int clr_at, output int cnt);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (!init_busy) break;
            chk("init_rdy0", {31'd0, req0_ready}, 32'd0);
            chk("init_rdy1", {31'd0, req1_ready}, 32'd0);
            chk("init_rs1", rs1_data, 32'd0);
            chk("init_rs2", rs2_data, 32'd0);
            clr = (cnt == clr_at);
            cnt++;
            @(negedge clk); #1;
        end
        clr = 1'b0;
    endtask

    // Behavioural reference state for the randomized phase.
    logic [31:0] mmem [NREG];
    int          busy_left;
    int          last;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        int w;
        logic v0, v1, c;
        logic [4:0] a0, a1, r1, r2;
        logic [31:0] d0, d1, e1, e2;

        // Vectors: expectations describe the cycle the inputs are applied.
        tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0};
        tbl[1] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[2] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h12345678, 5'd5, 5'd0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h0};
        tbl[3] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0};
        tbl[4] = '{1'b1, 5'd1, 32'h11110001, 1'b1, 5'd2, 32'h22220001, 5'd1, 5'd2, 1'b1, 1'b0, 32'h0, 32'h0};
        tbl[5] = '{1'b1, 5'd1, 32'h11110002, 1'b1, 5'd2, 32'h22220001, 5'd1, 5'd2, 1'b0, 1'b1, 32'h11110001, 32'h0};
        tbl[6] = '{1'b1, 5'd1, 32'h11110002, 1'b1, 5'd2, 32'h22220002, 5'd1, 5'd2, 1'b1, 1'b0, 32'h11110001, 32'h22220001};
        tbl[7] = '{1'b1, 5'd1, 32'h11110003, 1'b1, 5'd2, 32'h22220002, 5'd1, 5'd2, 1'b0, 1'b1, 32'h11110002, 32'h22220001};
        tbl[8] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 1'b0, 1'b0, 32'h11110002, 32'h22220002};

        // Power-up reset, then release and measure the init sweep.
        #1 rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1; #1;
        count_busy(-1, cnt);
        chk("init_cycles", cnt, 32'd32);

        // Every entry reads zero after the sweep.
        for (int a = 0; a < NREG; a++) begin
            rs1 = 5'(a); rs2 = 5'(NREG - 1 - a); #1;
            chk("post_init_rs1", rs1_data, 32'd0);
            chk("post_init_rs2", rs2_data, 32'd0);
        end
        @(negedge clk);

        // Single write, x0 write, alternating grants.
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1,
                  tbl[i].r1, tbl[i].r2, 1'b0);
            #1;
            chk($sformatf("vec%0d_rdy0", i), {31'd0, req0_ready}, {31'd0, tbl[i].e_rdy0});
            chk($sformatf("vec%0d_rdy1", i), {31'd0, req1_ready}, {31'd0, tbl[i].e_rdy1});
            chk($sformatf("vec%0d_rs1", i), rs1_data, tbl[i].e_rs1);
            chk($sformatf("vec%0d_rs2", i), rs2_data, tbl[i].e_rs2);
            @(negedge clk);
        end

        // Write x7, then clr alongside a write of x8; clr is pulsed again
        // mid-sweep and must not extend it.
        drive(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 32'h0, 5'd7, 5'd8, 1'b0); #1;
        chk("x7_rdy0", {31'd0, req0_ready}, 32'd1);
        @(negedge clk);
        drive(1'b1, 5'd8, 32'h1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd8, 1'b1); #1;
        chk("clr_wr_rdy0", {31'd0, req0_ready}, 32'd1);
        chk("clr_rs1_x7", rs1_data, 32'hA5A5A5A5);
        chk("clr_busy", {31'd0, init_busy}, 32'd0);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd8, 1'b0); #1;
        count_busy(5, cnt);
        chk("clr_init_cycles", cnt, 32'd32);
        chk("clr_x7", rs1_data, 32'd0);
        chk("clr_x8", rs2_data, 32'd0);
        @(negedge clk);

        // Reset again, interrupt the sweep at index 10 with valids held.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 5'd5, 5'd1, 1'b0);
        for (int i = 0; i < 10; i++) @(negedge clk);
        #1;
        chk("mid_init_busy", {31'd0, init_busy}, 32'd1);
        rst_n = 1'b0; #1;
        chk("rst_busy", {31'd0, init_busy}, 32'd1);
        chk("rst_rdy0", {31'd0, req0_ready}, 32'd0);
        chk("rst_rdy1", {31'd0, req1_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; #1;
        count_busy(-1, cnt);
        chk("rst_init_cycles", cnt, 32'd32);
        // First tie after reset goes to requester 0.
        chk("rst_tie_rdy0", {31'd0, req0_ready}, 32'd1);
        chk("rst_tie_rdy1", {31'd0, req1_ready}, 32'd0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
        @(negedge clk);
        // That tie was not clocked; state is freshly initialised.

        // Randomized run against the model.
        foreach (mmem[i]) mmem[i] = 32'd0;
        busy_left = 0;
        last = 1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            a0 = 5'($urandom_range(0, 31));
            a1 = 5'($urandom_range(0, 31));
            d0 = $urandom;
            d1 = $urandom;
            r1 = 5'($urandom_range(0, 31));
            r2 = 5'($urandom_range(0, 31));
            c  = ($urandom_range(0, 39) == 0);
            drive(v0, a0, d0, v1, a1, d1, r1, r2, c);
            #1;
            w = -1;
            if (busy_left == 0) begin
                if (v0 && v1) w = (last == 0) ? 1 : 0;
                else if (v0)  w = 0;
                else if (v1)  w = 1;
            end
            e1 = (busy_left > 0 || r1 == 0) ? 32'd0 : mmem[r1];
            e2 = (busy_left > 0 || r2 == 0) ? 32'd0 : mmem[r2];
            chk("rnd_busy", {31'd0, init_busy}, {31'd0, busy_left > 0});
            chk("rnd_rdy0", {31'd0, req0_ready}, {31'd0, w == 0});
            chk("rnd_rdy1", {31'd0, req1_ready}, {31'd0, w == 1});
            chk("rnd_rs1", rs1_data, e1);
            chk("rnd_rs2", rs2_data, e2);
            if (busy_left > 0) begin
                busy_left--;
            end else begin
                if (w == 0 && a0 != 0) mmem[a0] = d0;
                if (w == 1 && a1 != 0) mmem[a1] = d1;
                if (w >= 0) last = w;
                if (c) begin
                    busy_left = NREG;
                    foreach (mmem[i]) mmem[i] = 32'd0;
                end
            end
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
